// File: rtl/mem_arb_pkg.sv
// Shared types and sizes for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int SIZE      = 1024;
  localparam int ADDR_W    = $clog2(SIZE);
  localparam int DATA_W    = 32;
  localparam int PORT_LSU  = 0;
  localparam int PORT_IF   = 1;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_arb_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the two requesters.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise the LSU port always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_ARB_RR_EN
  input  logic                 last_ptr,
`endif
  output logic [NUM_PORTS-1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req[PORT_LSU] && req[PORT_IF]) begin
`ifdef MEM_ARB_RR_EN
      // favour whichever port was not granted last time
      gnt = last_ptr ? 2'b01 : 2'b10;
`else
      gnt = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port memory: grant, one memory access cycle, response pulse.
// Define MEM_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (port 0 first).
//
// state  | meaning
// IDLE   | no transaction in flight; may grant
// ACCESS | latched request driven to the memory; read data captured at the closing edge
// RESP   | rvalid pulse to the latched port; may grant the next request
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_o,
  output logic                              mem_we_o,
  output logic                              mem_re_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  output logic [DATA_W-1:0]                 mem_wdata_o,
  input  logic [DATA_W-1:0]                 mem_rdata_i
);

  mem_arb_state_t       state_q, state_d;
  logic                 id_q, id_d;
  mem_arb_req_t         req_q, req_d;
  logic [DATA_W-1:0]    rdata_q;
  logic [NUM_PORTS-1:0] pick_gnt;

`ifdef MEM_ARB_RR_EN
  logic last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_q <= 1'b0;
    else if (|gnt_o) last_q <= gnt_o[PORT_IF];
  end

  mem_arb_pick u_pick (
    .req      (req_i),
    .last_ptr (last_q),
    .gnt      (pick_gnt)
  );
`else
  mem_arb_pick u_pick (
    .req (req_i),
    .gnt (pick_gnt)
  );
`endif

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    req_d    = req_q;
    gnt_o    = '0;
    rvalid_o = '0;
    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) rvalid_o[id_q] = 1'b1;
        gnt_o = pick_gnt;
        if (|pick_gnt) begin
          state_d     = ACCESS;
          id_d        = pick_gnt[PORT_IF];
          req_d.we    = we_i[id_d];
          req_d.addr  = addr_i[id_d];
          req_d.wdata = wdata_i[id_d];
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 1'b0;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      req_q   <= req_d;
      if (state_q == ACCESS) rdata_q <= mem_rdata_i;
    end
  end

  // enables are decoded from the state register so reset removes them at once
  assign mem_we_o    = (state_q == ACCESS) &&  req_q.we;
  assign mem_re_o    = (state_q == ACCESS) && !req_q.we;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rdata_o[p] = rvalid_o[p] ? rdata_q : '0;
    end
  end

endmodule
